// File: rtl/playback_rate_engine_if.sv
// Codec-side request/response and SRAM read port of the playback engine, bundled.
interface playback_rate_engine_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic              sample_req;
  logic              fast;
  logic              slow;
  logic              interp;
  logic [3:0]        rate;
  logic              pause;
  logic              stop;
  logic [ADDR_W-1:0] end_addr;
  logic              rd_req;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dac_sample;
  logic              dac_valid;
  logic              done;
  logic              overrun;

  modport master (
    output sample_req, fast, slow, interp, rate, pause, stop, end_addr, rd_ack, rd_data,
    input  rd_req, address, dac_sample, dac_valid, done, overrun
  );
  modport slave (
    input  sample_req, fast, slow, interp, rate, pause, stop, end_addr, rd_ack, rd_data,
    output rd_req, address, dac_sample, dac_valid, done, overrun
  );
endinterface

// File: rtl/playback_rate_engine.sv
// Per codec frame request: fetch SRAM samples, apply skip / hold / linear-interp
// speed ratio, return one sample plus the current play address.
module playback_rate_engine #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int FRAME_MIN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  playback_rate_engine_if.slave bus
);
  localparam int DIV_W = DATA_W + 4;  // |cur-prev| * k with k < 8

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CALC, S_OUT} state_t;
  typedef enum logic [1:0] {OP_ZERO, OP_HOLD, OP_CUR, OP_INTERP} op_t;
  typedef struct packed {
    logic       fast;
    logic       slow;
    logic       interp;
    logic [3:0] rate;
  } mode_t;
  localparam mode_t MODE_NORMAL = '{fast: 1'b1, slow: 1'b0, interp: 1'b0, rate: 4'd1};

  // Worst-case frame: accept, fetch, divider load, DIV_W steps, output.
  if (FRAME_MIN <= DIV_W + 3) begin : g_frame_chk
    $error("FRAME_MIN too small for interpolation latency");
  end

  state_t              state, state_nxt;
  op_t                 op;
  mode_t               mode_q, mode_new;
  logic [2:0]          k, k_acc;
  logic [DATA_W-1:0]   prev, cur;
  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   dac_sample;
  logic                dac_valid, done, overrun, rd_req;
  logic [3:0]          rate_eff;
  logic                is_slow;

  logic [DIV_W-1:0]    div_q;
  logic [3:0]          div_rem;
  logic [4:0]          div_cnt;
  logic                div_busy, div_neg, div_last, div_ge;
  logic [4:0]          div_trial, div_sub;
  logic [DATA_W:0]     diff, diff_abs;
  logic [DIV_W:0]      quot_s, interp_y;

  logic                k_wrap, past_end;
  logic [3:0]          step;
  logic [ADDR_W:0]     addr_sum;

  // Mode decode at accept; normal play is fast mode with ratio 1.
  always_comb begin
    rate_eff = (bus.rate == 4'd0 || bus.rate > 4'd8) ? 4'd1 : bus.rate;
    is_slow  = bus.slow && !bus.fast;
    mode_new = '{fast: !is_slow, slow: is_slow, interp: is_slow && bus.interp,
                 rate: (bus.fast || is_slow) ? rate_eff : 4'd1};
    k_acc    = (mode_new != mode_q) ? 3'd0 : k;
  end

  always_comb begin
    diff      = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
    diff_abs  = diff[DATA_W] ? -diff : diff;
    div_trial = {div_rem, div_q[DIV_W-1]};
    div_ge    = div_trial >= {1'b0, mode_q.rate};
    div_sub   = div_trial - {1'b0, mode_q.rate};
    div_last  = div_busy && (div_cnt == 5'd1);
    quot_s    = div_neg ? -{1'b0, div_q} : {1'b0, div_q};
    interp_y  = {{(DIV_W+1-DATA_W){prev[DATA_W-1]}}, prev} + quot_s;
  end

  always_comb begin
    k_wrap   = ({1'b0, k} == mode_q.rate - 4'd1);
    step     = mode_q.fast ? mode_q.rate : (k_wrap ? 4'd1 : 4'd0);
    addr_sum = {1'b0, address} + {{(ADDR_W-3){1'b0}}, step};
    past_end = addr_sum > {1'b0, bus.end_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    case (state)
      S_IDLE: if (bus.sample_req) begin
        if (bus.stop || bus.pause || done)  state_nxt = S_OUT;
        else if (!is_slow || k_acc == 3'd0) state_nxt = S_FETCH;
        else if (mode_new.interp)           state_nxt = S_CALC;
        else                                state_nxt = S_OUT;
      end
      S_FETCH: begin
        rd_req = 1'b1;
        if (bus.rd_ack) state_nxt = mode_q.interp ? S_CALC : S_OUT;
      end
      S_CALC:  if (div_last) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op         <= OP_ZERO;
      mode_q     <= MODE_NORMAL;
      k          <= '0;
      prev       <= '0;
      cur        <= '0;
      address    <= '0;
      dac_sample <= '0;
      dac_valid  <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      div_q      <= '0;
      div_rem    <= '0;
      div_cnt    <= '0;
      div_busy   <= 1'b0;
      div_neg    <= 1'b0;
    end else begin
      dac_valid <= 1'b0;
      if (bus.sample_req && state != S_IDLE) overrun <= 1'b1;
      case (state)
        S_IDLE: if (bus.sample_req) begin
          div_busy <= 1'b0;
          if (bus.stop) begin
            address <= '0;
            k       <= '0;
            done    <= 1'b0;
            op      <= OP_ZERO;
          end else if (bus.pause || done) begin
            op <= OP_HOLD;
          end else begin
            mode_q <= mode_new;
            k      <= k_acc;
            op     <= mode_new.interp ? OP_INTERP : OP_CUR;
          end
        end
        S_FETCH: if (bus.rd_ack) begin
          prev <= cur;
          cur  <= bus.rd_data;
        end
        // Restoring divide of |(cur-prev)*k| by rate; sign reapplied afterwards.
        S_CALC: begin
          if (!div_busy) begin
            div_q    <= DIV_W'(diff_abs[DATA_W-1:0]) * DIV_W'(k);
            div_neg  <= diff[DATA_W];
            div_rem  <= '0;
            div_cnt  <= 5'(DIV_W);
            div_busy <= 1'b1;
          end else begin
            div_q   <= {div_q[DIV_W-2:0], div_ge};
            div_rem <= div_ge ? div_sub[3:0] : div_trial[3:0];
            div_cnt <= div_cnt - 5'd1;
          end
        end
        S_OUT: begin
          dac_valid <= 1'b1;
          case (op)
            OP_ZERO:   dac_sample <= '0;
            OP_HOLD:   dac_sample <= dac_sample;
            OP_CUR:    dac_sample <= cur;
            OP_INTERP: dac_sample <= interp_y[DATA_W-1:0];
            default:   dac_sample <= dac_sample;
          endcase
          if (op == OP_CUR || op == OP_INTERP) begin
            if (!mode_q.fast) k <= k_wrap ? 3'd0 : k + 3'd1;
            if (step != 4'd0) begin
              if (past_end) begin
                address <= bus.end_addr;
                done    <= 1'b1;
              end else begin
                address <= addr_sum[ADDR_W-1:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_req     = rd_req;
  assign bus.address    = address;
  assign bus.dac_sample = dac_sample;
  assign bus.dac_valid  = dac_valid;
  assign bus.done       = done;
  assign bus.overrun    = overrun;
endmodule

// File: tb/tb_playback_rate_engine.sv
// Directed bench for playback_rate_engine: arithmetic reference model plus
// hand-computed literal checkpoints.
module tb_playback_rate_engine;
  localparam int ADDR_W = 18, DATA_W = 16, FRAME_MIN = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  playback_rate_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  playback_rate_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_MIN(FRAME_MIN)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [DATA_W-1:0] s;
    logic [ADDR_W-1:0] a;
    logic              d;
  } exp_t;

  exp_t              exp_q[$];
  int                n_cmp = 0, n_fail = 0;
  int                ack_delay = 0;
  logic [DATA_W-1:0] sram [0:63];
  int                m_addr, m_done, m_k, m_prev, m_cur, m_out, m_key;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 0; m_done = 0; m_k = 0; m_prev = 0; m_cur = 0; m_out = 0; m_key = 101;
    exp_q.delete();
  endtask

  // Speed-ratio rules in plain integer arithmetic; returns expected fetch latency or -1.
  task automatic model_req(input bit st, pa, fa, sl, ip, input int rt, output int lat);
    int r, key, na;
    bit is_fast, fetched;
    r = (rt == 0 || rt > 8) ? 1 : rt;
    lat = -1;
    fetched = 0;
    if (st) begin
      m_addr = 0; m_k = 0; m_done = 0; m_out = 0;
    end else if (!(pa || m_done != 0)) begin
      is_fast = fa || !sl;
      if (is_fast && !fa) r = 1;
      key = is_fast ? 100 + r : (ip ? 300 + r : 200 + r);
      if (key != m_key) m_k = 0;
      m_key = key;
      if (is_fast || m_k == 0) begin
        m_prev = m_cur;
        m_cur  = $signed(sram[m_addr]);
        fetched = 1;
      end
      if (!is_fast && ip) m_out = m_prev + ((m_cur - m_prev) * m_k) / r;
      else                m_out = m_cur;
      if (fetched && !(!is_fast && ip)) lat = 2 + ack_delay;
      na = m_addr;
      if (is_fast) na = m_addr + r;
      else if (m_k == r - 1) begin m_k = 0; na = m_addr + 1; end
      else m_k++;
      if (na != m_addr) begin
        if (na > int'(bus.end_addr) || na > (1 << ADDR_W) - 1) begin
          m_addr = int'(bus.end_addr); m_done = 1;
        end else m_addr = na;
      end
    end
    exp_q.push_back('{s: m_out[DATA_W-1:0], a: m_addr[ADDR_W-1:0], d: m_done[0]});
  endtask

  task automatic issue(input bit st, pa, fa, sl, ip, input logic [3:0] rt, output int lat);
    @(negedge clk);
    bus.stop = st; bus.pause = pa; bus.fast = fa; bus.slow = sl; bus.interp = ip;
    bus.rate = rt; bus.sample_req = 1'b1;
    model_req(st, pa, fa, sl, ip, int'(rt), lat);
    @(negedge clk);
    bus.sample_req = 1'b0;
  endtask

  // j counts negedges since the request was sampled; latency = clock edges to dac_valid.
  task automatic wait_valid(input int lat, input int j0, input bit bound);
    int j;
    j = j0;
    while (bus.dac_valid !== 1'b1 && j < 200) begin
      @(negedge clk);
      j++;
    end
    if (j >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout: no dac_valid within %0d cycles, required one", j);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      if (lat >= 0) check("latency", j - 1, lat);
      if (bound) check("latency_bound", 32'(j - 1 < FRAME_MIN), 1);
    end
  endtask

  task automatic req(input bit st, pa, fa, sl, ip, input logic [3:0] rt);
    int lat;
    issue(st, pa, fa, sl, ip, rt, lat);
    wait_valid(lat, 1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // SRAM responder: acks after ack_delay idle cycles of rd_req.
  initial begin
    int w;
    w = 0;
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      bus.rd_ack = 1'b0;
      if (bus.rd_req === 1'b1 && !reset) begin
        if (w >= ack_delay) begin
          bus.rd_ack = 1'b1;
          bus.rd_data = sram[bus.address[5:0]];
          w = 0;
        end else w++;
      end else w = 0;
    end
  end

  // Compare process: every output pulse is checked against the model queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.dac_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_valid: dac_valid=1 expected 0");
        end else begin
          e = exp_q.pop_front();
          check("dac_sample", bus.dac_sample, e.s);
          check("address", bus.address, e.a);
          check("done", bus.done, e.d);
        end
      end
    end
  end

  initial begin
    int lat;
    reset = 1'b1;
    bus.sample_req = 0; bus.fast = 0; bus.slow = 0; bus.interp = 0;
    bus.pause = 0; bus.stop = 0; bus.rate = 4'd1; bus.end_addr = 18'd63;
    for (int i = 0; i < 64; i++) sram[i] = 16'(i * 100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_address", bus.address, 0);
    check("rst_dac_sample", bus.dac_sample, 0);
    check("rst_dac_valid", bus.dac_valid, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_done", bus.done, 0);
    check("rst_overrun", bus.overrun, 0);

    // Normal play, then pause, a slow SRAM, and slow hold
    for (int i = 0; i < 5; i++) req(0, 0, 0, 0, 0, 4'd1);
    check("normal_last", bus.dac_sample, 400);
    check("normal_addr", bus.address, 5);
    req(0, 1, 0, 0, 0, 4'd1);
    check("pause_sample", bus.dac_sample, 400);
    check("pause_addr", bus.address, 5);
    ack_delay = 2;
    req(0, 0, 0, 0, 0, 4'd1);
    ack_delay = 0;
    for (int i = 0; i < 4; i++) req(0, 0, 0, 1, 0, 4'd3);
    check("hold_last", bus.dac_sample, 700);

    // Fast skip, then out-of-range rates acting as 1
    do_reset();
    for (int i = 0; i < 4; i++) req(0, 0, 1, 0, 0, 4'd3);
    check("fast_last", bus.dac_sample, 900);
    check("fast_addr", bus.address, 12);
    req(0, 0, 1, 0, 0, 4'd0);
    req(0, 0, 1, 0, 0, 4'd0);
    req(0, 0, 1, 0, 0, 4'd12);
    check("rate_clamp_addr", bus.address, 15);

    // Slow interpolation, rate 4
    do_reset();
    sram[0] = 16'd0; sram[1] = 16'd400;
    for (int i = 0; i < 8; i++) req(0, 0, 0, 1, 1, 4'd4);
    check("interp4_last", bus.dac_sample, 300);

    // Truncation toward zero, then full-scale swings at rate 7
    do_reset();
    sram[0] = 16'd0; sram[1] = 16'hFFFD;
    for (int i = 0; i < 4; i++) req(0, 0, 0, 1, 1, 4'd2);
    check("interp_trunc", bus.dac_sample, 16'hFFFF);
    sram[2] = 16'h8000; sram[3] = 16'h7FFF;
    for (int i = 0; i < 14; i++) req(0, 0, 0, 1, 1, 4'd7);

    // End of recording, stop, and overshooting skip
    do_reset();
    for (int i = 0; i < 16; i++) sram[i] = 16'(i * 100);
    bus.end_addr = 18'd2;
    for (int i = 0; i < 5; i++) req(0, 0, 0, 0, 0, 4'd1);
    check("end_done", bus.done, 1);
    check("end_addr", bus.address, 2);
    check("end_repeat", bus.dac_sample, 200);
    req(1, 0, 0, 0, 0, 4'd1);
    check("stop_addr", bus.address, 0);
    check("stop_sample", bus.dac_sample, 0);
    check("stop_done", bus.done, 0);
    bus.end_addr = 18'd10;
    for (int i = 0; i < 3; i++) req(0, 0, 1, 0, 0, 4'd8);
    check("skip_end_addr", bus.address, 10);
    check("skip_end_sample", bus.dac_sample, 800);

    // Request while waiting on a slow SRAM
    do_reset();
    bus.end_addr = 18'd63;
    ack_delay = 40;
    issue(0, 0, 0, 0, 0, 4'd1, lat);
    repeat (3) @(negedge clk);
    check("ovr_rd_req", bus.rd_req, 1);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    check("overrun_set", bus.overrun, 1);
    wait_valid(lat, 5, 1'b0);
    ack_delay = 0;
    req(1, 0, 0, 0, 0, 4'd1);
    check("ovr_stop_addr", bus.address, 0);
    check("overrun_sticky", bus.overrun, 1);

    // Reset while a fetch is outstanding
    ack_delay = 40;
    issue(0, 0, 0, 0, 0, 4'd1, lat);
    repeat (3) @(negedge clk);
    check("mid_rd_req", bus.rd_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("mid_rst_rd_req", bus.rd_req, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_address", bus.address, 0);
    repeat (60) @(negedge clk);
    ack_delay = 0;
    req(0, 0, 0, 0, 0, 4'd1);
    check("post_rst_addr", bus.address, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
